// File: rtl/spd_i2c_arbiter.sv
// Round-robin arbiter granting several SPD requesters access to one I2C byte engine.
// Each transaction: IDLE -> START (engine kick) -> WAIT (done or timeout) -> RESP (done pulse).
module spd_i2c_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [7*NUM_REQ-1:0] i_req_slave,
  input  logic [8*NUM_REQ-1:0] i_req_reg,
  input  logic [NUM_REQ-1:0]   i_req_rw,
  input  logic [8*NUM_REQ-1:0] i_req_wdata,
  output logic [NUM_REQ-1:0]   o_gnt,
  output logic [NUM_REQ-1:0]   o_done,
  output logic [7:0]           o_rdata,
  output logic                 o_nack,
  output logic                 o_timeout,
  output logic                 o_eng_start,
  output logic                 o_eng_abort,
  output logic [6:0]           o_eng_slave,
  output logic [7:0]           o_eng_reg,
  output logic                 o_eng_rw,
  output logic [7:0]           o_eng_wdata,
  input  logic                 i_eng_busy,
  input  logic                 i_eng_done,
  input  logic                 i_eng_nack,
  input  logic [7:0]           i_eng_rdata
);

  localparam int          IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d, win_q, win_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d, done_q, done_d;
  logic                start_q, start_d, abort_q, abort_d;
  logic [7:0]          rdata_q, rdata_d;
  logic                nack_q, nack_d, tmo_q, tmo_d;
  logic [6:0]          slave_q, slave_d;
  logic [7:0]          reg_q, reg_d, wdata_q, wdata_d;
  logic                rw_q, rw_d;
  logic                found_s;
  logic [IW-1:0]       pick_s;
  int                  idx_s;

  // Round-robin scan: first active request at or after rr_ptr, wrapping.
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    idx_s   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_s = int'(rr_ptr_q) + i;
      if (idx_s >= NUM_REQ) begin
        idx_s = idx_s - NUM_REQ;
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && i_req[IW'(idx_s)]) begin
        found_s = 1'b1;
        pick_s  = IW'(idx_s);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    start_d  = 1'b0;
    abort_d  = 1'b0;
    rdata_d  = rdata_q;
    nack_d   = nack_q;
    tmo_d    = tmo_q;
    slave_d  = slave_q;
    reg_d    = reg_q;
    rw_d     = rw_q;
    wdata_d  = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (found_s && !i_eng_busy) begin
          state_d = S_START;
          win_d   = pick_s;
          gnt_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_s;
          start_d = 1'b1;
          slave_d = 7'(i_req_slave >> (7 * int'(pick_s)));
          reg_d   = 8'(i_req_reg >> (8 * int'(pick_s)));
          wdata_d = 8'(i_req_wdata >> (8 * int'(pick_s)));
          rw_d    = i_req_rw[pick_s];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        cnt_d   = 16'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Completion wins over timeout when both land on the last counted cycle.
        if (i_eng_done) begin
          rdata_d = i_eng_rdata;
          nack_d  = i_eng_nack;
          tmo_d   = 1'b0;
          done_d  = gnt_q;
          state_d = S_RESP;
        end else if (cnt_q == TMO_LAST) begin
          abort_d = 1'b1;
          rdata_d = 8'd0;
          nack_d  = 1'b0;
          tmo_d   = 1'b1;
          done_d  = gnt_q;
          cnt_d   = cnt_q + 16'd1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RESP: begin
        gnt_d    = '0;
        rr_ptr_d = (win_q == IW'(NUM_REQ - 1)) ? '0 : win_q + IW'(1);
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      win_q    <= '0;
      cnt_q    <= 16'd0;
      gnt_q    <= '0;
      done_q   <= '0;
      start_q  <= 1'b0;
      abort_q  <= 1'b0;
      rdata_q  <= 8'd0;
      nack_q   <= 1'b0;
      tmo_q    <= 1'b0;
      slave_q  <= 7'd0;
      reg_q    <= 8'd0;
      rw_q     <= 1'b0;
      wdata_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      win_q    <= win_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      start_q  <= start_d;
      abort_q  <= abort_d;
      rdata_q  <= rdata_d;
      nack_q   <= nack_d;
      tmo_q    <= tmo_d;
      slave_q  <= slave_d;
      reg_q    <= reg_d;
      rw_q     <= rw_d;
      wdata_q  <= wdata_d;
    end
  end

  assign o_gnt       = gnt_q;
  assign o_done      = done_q;
  assign o_rdata     = rdata_q;
  assign o_nack      = nack_q;
  assign o_timeout   = tmo_q;
  assign o_eng_start = start_q;
  assign o_eng_abort = abort_q;
  assign o_eng_slave = slave_q;
  assign o_eng_reg   = reg_q;
  assign o_eng_rw    = rw_q;
  assign o_eng_wdata = wdata_q;

endmodule

// File: tb/tb_spd_i2c_arbiter.sv
// Directed bench for spd_i2c_arbiter: 4 requesters, 100-cycle timeout, hand-computed expectations.
module tb_spd_i2c_arbiter;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [3:0]  i_req;
  logic [27:0] i_req_slave;
  logic [31:0] i_req_reg;
  logic [3:0]  i_req_rw;
  logic [31:0] i_req_wdata;
  logic [3:0]  o_gnt, o_done;
  logic [7:0]  o_rdata;
  logic        o_nack, o_timeout, o_eng_start, o_eng_abort;
  logic [6:0]  o_eng_slave;
  logic [7:0]  o_eng_reg, o_eng_wdata;
  logic        o_eng_rw;
  logic        i_eng_busy, i_eng_done, i_eng_nack;
  logic [7:0]  i_eng_rdata;

  int total = 0;
  int bad   = 0;
  int cnt;
  logic [3:0] rw_tab = 4'b0101;

  spd_i2c_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(100)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_req(i_req), .i_req_slave(i_req_slave),
    .i_req_reg(i_req_reg), .i_req_rw(i_req_rw), .i_req_wdata(i_req_wdata),
    .o_gnt(o_gnt), .o_done(o_done), .o_rdata(o_rdata), .o_nack(o_nack),
    .o_timeout(o_timeout), .o_eng_start(o_eng_start), .o_eng_abort(o_eng_abort),
    .o_eng_slave(o_eng_slave), .o_eng_reg(o_eng_reg), .o_eng_rw(o_eng_rw),
    .o_eng_wdata(o_eng_wdata), .i_eng_busy(i_eng_busy), .i_eng_done(i_eng_done),
    .i_eng_nack(i_eng_nack), .i_eng_rdata(i_eng_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Full transaction for winner w; engine answers lat cycles after the START cycle.
  task automatic txn(input string tag, input logic [3:0] req, input int w, input int lat,
                     input logic [7:0] rd, input logic nk, input logic [3:0] mid_req);
    int extra;
    logic [3:0] eg;
    logic [6:0] es;
    eg = 4'b0001 << w;
    es = 7'(8'h50 + w);
    extra = 0;
    i_req = req;
    tick();
    chk({tag, " gnt"},   32'(o_gnt), 32'(eg));
    chk({tag, " start"}, 32'(o_eng_start), 32'd1);
    chk({tag, " ops"}, {o_eng_reg, o_eng_wdata, 7'd0, o_eng_rw, 1'b0, o_eng_slave},
        {8'(16 * w), 8'(8'hA0 + w), 7'd0, rw_tab[w], 1'b0, es});
    for (int k = 0; k < lat; k++) begin
      tick();
      if (k == 0) i_req = mid_req;
      extra += int'(o_eng_start) + int'(o_eng_abort) + int'(o_done != 4'd0);
    end
    chk({tag, " extra"}, 32'(extra), 32'd0);
    i_eng_done = 1'b1; i_eng_rdata = rd; i_eng_nack = nk;
    tick();
    i_eng_done = 1'b0; i_eng_rdata = 8'h00; i_eng_nack = 1'b0;
    chk({tag, " done"},   32'(o_done), 32'(eg));
    chk({tag, " result"}, {21'd0, o_eng_abort, o_timeout, o_nack, o_rdata},
        {21'd0, 1'b0, 1'b0, nk, rd});
    chk({tag, " hold"},   {o_gnt, 1'b0, o_eng_slave}, {eg, 1'b0, es});
    tick();
    chk({tag, " end"},    {o_gnt, o_done, o_rdata}, {4'd0, 4'd0, rd});
  endtask

  initial begin
    i_rst = 1'b1; i_req = 4'd0; i_eng_busy = 1'b0; i_eng_done = 1'b0;
    i_eng_nack = 1'b0; i_eng_rdata = 8'd0; i_req_rw = rw_tab;
    i_req_slave = {7'h53, 7'h52, 7'h51, 7'h50};
    i_req_reg   = {8'h30, 8'h20, 8'h10, 8'h00};
    i_req_wdata = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    tick(); tick();
    i_rst = 1'b0;
    chk("reset", {o_gnt, o_done, o_eng_start, o_eng_abort, o_rdata, o_nack, o_timeout},
        {4'd0, 4'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0});

    txn("single", 4'b0001, 0, 20, 8'h92, 1'b0, 4'b0001);
    i_req = 4'd0;

    i_rst = 1'b1; tick(); i_rst = 1'b0;
    for (int r = 0; r < 5; r++) txn("rr", 4'b1111, r % 4, 3 + r, 8'h90 + 8'(r), 1'b0, 4'b1111);

    txn("nack", 4'b0010, 1, 7, 8'h5A, 1'b1, 4'b1101);
    txn("edge", 4'b1000, 3, 100, 8'h3C, 1'b0, 4'b0000);

    i_req = 4'b0001;
    tick();
    chk("to gnt", 32'(o_gnt), 32'd1);
    i_req = 4'b0000;
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      cnt += int'(o_eng_abort) + int'(o_done != 4'd0);
    end
    chk("to early", 32'(cnt), 32'd0);
    tick();
    chk("to abort", {o_eng_abort, o_done, o_timeout, o_nack, o_rdata},
        {1'b1, 4'b0001, 1'b1, 1'b0, 8'h00});
    tick();
    chk("to end", {o_eng_abort, o_done, o_gnt, o_timeout}, {1'b0, 4'd0, 4'd0, 1'b1});

    i_eng_busy = 1'b1; i_req = 4'b0010;
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      cnt += int'(o_gnt != 4'd0);
    end
    chk("busy", 32'(cnt), 32'd0);
    i_eng_busy = 1'b0;
    txn("busy", 4'b0010, 1, 4, 8'hC7, 1'b0, 4'b0000);

    i_req = 4'b1000;
    tick();
    chk("rst gnt", 32'(o_gnt), 32'b1000);
    i_req = 4'b0000;
    for (int k = 0; k < 5; k++) tick();
    i_rst = 1'b1; tick(); i_rst = 1'b0;
    chk("rst outs", {o_gnt, o_done, o_eng_start, o_eng_abort, o_rdata, o_nack, o_timeout},
        {4'd0, 4'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0});
    chk("rst ops", {o_eng_slave, o_eng_reg, o_eng_rw, o_eng_wdata}, 32'd0);
    i_eng_done = 1'b1; i_eng_rdata = 8'h77;
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      i_eng_done = 1'b0;
      cnt += int'(o_done != 4'd0) + int'(o_eng_abort);
    end
    chk("rst quiet", 32'(cnt), 32'd0);
    txn("post", 4'b0100, 2, 5, 8'h21, 1'b0, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spd_i2c_arbiter.md
SPD_I2C_ARBITER -- requirements
Module: spd_i2c_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535, maximum WAIT-state cycles before abort (16-bit).
REQ-003 SHALL have port i_clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_req  input  NUM_REQ  per-requester transaction request, level.
REQ-006 SHALL have port i_req_slave  input  7*NUM_REQ  packed I2C slave address per requester.
REQ-007 SHALL have port i_req_reg  input  8*NUM_REQ  packed register/byte address per requester.
REQ-008 SHALL have port i_req_rw  input  NUM_REQ  per-requester direction, 1=read.
REQ-009 SHALL have port i_req_wdata  input  8*NUM_REQ  packed write byte per requester.
REQ-010 SHALL have port o_gnt  output  NUM_REQ  one-hot grant, held for the whole transaction.
REQ-011 SHALL have port o_done  output  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-012 SHALL have port o_rdata / o_nack / o_timeout  output  8/1/1  result, valid in the o_done cycle.
REQ-013 SHALL have port o_eng_start / o_eng_abort  output  1/1  one-cycle command pulses to the I2C byte engine.
REQ-014 SHALL have port o_eng_slave / o_eng_reg / o_eng_rw / o_eng_wdata  output  7/8/1/8  latched operands, stable from START until return to IDLE.
REQ-015 SHALL have port i_eng_busy / i_eng_done / i_eng_nack  input  1/1/1  engine status; done is a one-cycle pulse.
REQ-016 SHALL have port i_eng_rdata  input  8  engine read byte, valid with i_eng_done.

Function
REQ-017 SHALL implement FSM states IDLE, START, WAIT, RESP.
REQ-018 IDLE: when |i_req and !i_eng_busy, SHALL select winner round-robin starting at pointer rr_ptr, set o_gnt one-hot and latch winner's operands, go to START next cycle.
REQ-019 IDLE with i_eng_busy=1 SHALL not grant; requests wait.
REQ-020 START: SHALL pulse o_eng_start for exactly one cycle, clear timeout counter, go to WAIT.
REQ-021 WAIT: on i_eng_done SHALL capture i_eng_rdata and i_eng_nack, go to RESP.
REQ-022 WAIT: counter increments per cycle; when it equals TIMEOUT_CYCLES without i_eng_done SHALL pulse o_eng_abort one cycle, set o_timeout=1, o_rdata=0, o_nack=0, go to RESP.
REQ-023 i_eng_done in the same cycle the counter reaches TIMEOUT_CYCLES SHALL be treated as completion (no abort, o_timeout=0).
REQ-024 RESP: SHALL pulse o_done[winner] one cycle with result; o_gnt deasserted the following cycle; rr_ptr = (winner+1) mod NUM_REQ; go to IDLE.
REQ-025 Latency: request sampled in IDLE cycle T -> o_gnt at T+1, o_eng_start at T+1, o_done one cycle after RESP entry (i_eng_done cycle + 1).
REQ-026 Requester dropping i_req after grant SHALL not abort; transaction completes and o_done still pulses.
REQ-027 i_req changes on non-granted requesters during a transaction SHALL not affect latched operands or grant.
REQ-028 Minimum idle gap: one IDLE cycle between consecutive transactions.
REQ-029 Round-robin wrap: winner NUM_REQ-1 -> rr_ptr 0; no requester starves with all requests held.
REQ-030 o_rdata, o_nack, o_timeout SHALL hold last values between o_done pulses.

Reset
REQ-031 i_rst=1 SHALL force state IDLE, rr_ptr=0, counter=0, o_gnt=0, o_done=0, o_eng_start=0, o_eng_abort=0, o_rdata=0, o_nack=0, o_timeout=0, engine operands=0, effective next edge.
REQ-032 Reset during START/WAIT/RESP SHALL drop the transaction with no o_done and no o_eng_abort pulse.

Verification
REQ-033 Single read: i_req=0001, slave 0x50, reg 0x00, rw=1; engine done after 20 cycles with rdata 0x92 -> o_gnt=0001, one o_eng_start, o_done=0001, o_rdata=0x92, o_nack=0.
REQ-034 Round-robin: i_req=1111 held -> grant order 0,1,2,3,0; each o_done once per round.
REQ-035 NACK: engine done with i_eng_nack=1 for slave 0x51 -> o_done with o_nack=1, o_timeout=0.
REQ-036 Timeout: TIMEOUT_CYCLES=100, engine never done -> o_eng_abort exactly 100 cycles after WAIT entry, o_done with o_timeout=1, o_rdata=0x00.
REQ-037 Busy gating: i_eng_busy=1 with i_req=0010 -> no grant until busy falls, grant next cycle.
REQ-038 Reset mid-WAIT: assert i_rst for one cycle -> all outputs 0, no o_done; subsequent request to requester 2 granted (rr_ptr=0 scan).
